// File: rtl/pacer_pkg.sv
// pacer_pkg: shared sense-channel state encoding and counter width for the pacemaker.
package pacer_pkg;
  localparam int CNT_W_DEF = 5;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUALIFY,
    ST_EVENT,
    ST_REFRACT,
    ST_REARM
  } ch_state_e;
endpackage

// File: rtl/sense_channel.sv
// sense_channel: synchronise, debounce and refractory-gate one electrode comparator input.
module sense_channel
  import pacer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 3,
  parameter int POST_LEN    = 8,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_i,
  input  logic             blk_i,
  input  logic [CNT_W-1:0] ref_len_i,
  output logic             sense_o,
  output logic             refr_o
);
  localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEB_CYC);
  localparam logic [CNT_W-1:0] POST_C = CNT_W'(POST_LEN);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  if (SYNC_STAGES < 2 || DEB_CYC < 1 || DEB_CYC >= 2 ** CNT_W || POST_LEN < 1 || POST_LEN >= 2 ** CNT_W)
    begin : g_bad_param
      $error("sense_channel: parameter out of range");
    end
  logic [SYNC_STAGES-1:0] sync_q;
  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, rem;
  logic                   s, sense_q, refr_q;
  assign s       = sync_q[SYNC_STAGES-1];
  assign rem     = cnt_q - ONE_C;
  assign sense_o = sense_q;
  assign refr_o  = refr_q;
  // A blank always wins over qualification; inside a window it can only extend it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:
        if (blk_i) begin
          state_d = ST_REFRACT;
          cnt_d   = ref_len_i;
        end else if (s) begin
          state_d = (DEB_CYC == 1) ? ST_EVENT : ST_QUALIFY;
          cnt_d   = ONE_C;
        end
      ST_QUALIFY:
        if (blk_i) begin
          state_d = ST_REFRACT;
          cnt_d   = ref_len_i;
        end else if (!s) begin
          state_d = ST_IDLE;
        end else if (cnt_q + ONE_C == DEB_C) begin
          state_d = ST_EVENT;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      ST_EVENT: begin
        state_d = ST_REFRACT;
        cnt_d   = (blk_i && ref_len_i > POST_C) ? ref_len_i : POST_C;
      end
      ST_REFRACT:
        if (blk_i) cnt_d = (rem > ref_len_i) ? rem : ref_len_i;
        else if (cnt_q == ONE_C) state_d = ST_REARM;
        else cnt_d = rem;
      ST_REARM:
        if (blk_i) begin
          state_d = ST_REFRACT;
          cnt_d   = ref_len_i;
        end else if (!s) begin
          state_d = ST_IDLE;
        end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sense_q <= 1'b0;
      refr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sense_q <= state_d == ST_EVENT;
      refr_q  <= state_d == ST_REFRACT;
    end
endmodule

// File: rtl/sense_conditioner.sv
// sense_conditioner: atrial/ventricular sense front end; pace and sense feedback drive the
// cross-channel blanking windows.
module sense_conditioner
  import pacer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 3,
  parameter int ARP         = 8,
  parameter int PVARP       = 10,
  parameter int VRP         = 8,
  parameter int VBLANK      = 2,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic atrial_raw,
  input  logic vent_raw,
  input  logic pa,
  input  logic pv,
  output logic sa,
  output logic sv,
  output logic a_refr,
  output logic v_refr
);
  localparam logic [CNT_W-1:0] ARP_C    = CNT_W'(ARP);
  localparam logic [CNT_W-1:0] PVARP_C  = CNT_W'(PVARP);
  localparam logic [CNT_W-1:0] VRP_C    = CNT_W'(VRP);
  localparam logic [CNT_W-1:0] VBLANK_C = CNT_W'(VBLANK);
  if (ARP < 1 || PVARP < 1 || VRP < 1 || VBLANK < 1 || ARP >= 2 ** CNT_W || PVARP >= 2 ** CNT_W ||
      VRP >= 2 ** CNT_W || VBLANK >= 2 ** CNT_W)
    begin : g_bad_param
      $error("sense_conditioner: window parameter out of range");
    end
  logic             a_blk, v_blk;
  logic [CNT_W-1:0] a_ref, v_ref;
  // Concurrent blank sources resolve to the longest applicable window.
  assign a_blk = pa | pv | sv;
  assign a_ref = ((pv | sv) && (!pa || PVARP_C >= ARP_C)) ? PVARP_C : ARP_C;
  assign v_blk = pa | pv;
  assign v_ref = (pv && (!pa || VRP_C >= VBLANK_C)) ? VRP_C : VBLANK_C;
  sense_channel #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYC    (DEB_CYC),
    .POST_LEN   (ARP),
    .CNT_W      (CNT_W)
  ) u_atrial (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (atrial_raw),
    .blk_i    (a_blk),
    .ref_len_i(a_ref),
    .sense_o  (sa),
    .refr_o   (a_refr)
  );
  sense_channel #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYC    (DEB_CYC),
    .POST_LEN   (VRP),
    .CNT_W      (CNT_W)
  ) u_vent (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (vent_raw),
    .blk_i    (v_blk),
    .ref_len_i(v_ref),
    .sense_o  (sv),
    .refr_o   (v_refr)
  );
endmodule

// File: tb/tb_sense_conditioner.sv
// tb_sense_conditioner: directed scenarios plus random stimulus against a window-based reference model.
module tb_sense_conditioner;
  localparam int SYNC = 2, DEB = 3, ARP = 8, PVARP = 10, VRP = 8, VBLANK = 2;
  logic clk = 0, rst_n = 0, atrial_raw = 0, vent_raw = 0, pa = 0, pv = 0;
  logic sa, sv, a_refr, v_refr;
  int checks = 0, errors = 0;
  int rem[2], run[2];
  bit ev[2], armed[2];
  bit qa[$], qv[$];
  int n_sa, n_sv, n_ar, n_vr, first_sa, tk, a_at5;

  always #5 clk = ~clk;

  sense_conditioner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .atrial_raw(atrial_raw),
    .vent_raw  (vent_raw),
    .pa        (pa),
    .pv        (pv),
    .sa        (sa),
    .sv        (sv),
    .a_refr    (a_refr),
    .v_refr    (v_refr)
  );

  function automatic int imax(int a, int b);
    return a > b ? a : b;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa = {};
    qv = {};
    for (int c = 0; c < 2; c++) begin
      rem[c] = 0; run[c] = 0; ev[c] = 0; armed[c] = 1;
    end
    for (int i = 0; i < SYNC; i++) begin
      qa.push_back(1'b0);
      qv.push_back(1'b0);
    end
  endtask

  // One clock edge: a channel is either sensing, inside a window (rem>0), waiting
  // for the raw level to drop, or counting consecutive synced-high samples.
  task automatic model_step();
    bit s[2], b[2];
    int r[2], post[2];
    if (!rst_n) begin
      model_reset();
      return;
    end
    post[0] = ARP;
    post[1] = VRP;
    s[0] = qa.pop_front();
    qa.push_back(atrial_raw);
    s[1] = qv.pop_front();
    qv.push_back(vent_raw);
    b[0] = pa | pv | ev[1];
    r[0] = imax(pa ? ARP : 0, (pv | ev[1]) ? PVARP : 0);
    b[1] = pa | pv;
    r[1] = imax(pv ? VRP : 0, pa ? VBLANK : 0);
    for (int c = 0; c < 2; c++) begin
      if (ev[c]) begin
        ev[c] = 0;
        rem[c] = imax(post[c], b[c] ? r[c] : 0);
        run[c] = 0;
      end else if (rem[c] > 0) begin
        rem[c] = b[c] ? imax(rem[c] - 1, r[c]) : rem[c] - 1;
        if (rem[c] == 0) armed[c] = 0;
      end else if (!armed[c]) begin
        if (b[c]) rem[c] = r[c];
        else if (!s[c]) armed[c] = 1;
      end else if (b[c]) begin
        rem[c] = r[c];
        run[c] = 0;
      end else if (s[c]) begin
        run[c]++;
        if (run[c] == DEB) begin
          ev[c] = 1;
          run[c] = 0;
        end
      end else begin
        run[c] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    chk("sa", {31'b0, sa}, {31'b0, ev[0]});
    chk("sv", {31'b0, sv}, {31'b0, ev[1]});
    chk("a_refr", {31'b0, a_refr}, {31'b0, rem[0] > 0});
    chk("v_refr", {31'b0, v_refr}, {31'b0, rem[1] > 0});
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    tk++;
    n_sa += int'(sa);
    n_sv += int'(sv);
    n_ar += int'(a_refr);
    n_vr += int'(v_refr);
    if (sa === 1'b1 && first_sa == 0) first_sa = tk;
  endtask

  task automatic clr();
    n_sa = 0; n_sv = 0; n_ar = 0; n_vr = 0; first_sa = 0; tk = 0;
  endtask

  task automatic quiet(int n);
    atrial_raw = 0; vent_raw = 0; pa = 0; pv = 0;
    repeat (n) tick();
  endtask

  initial begin
    model_reset();
    clr();
    rst_n = 0;
    repeat (3) tick();
    chk("rst_sa", {31'b0, sa}, 0);
    chk("rst_sv", {31'b0, sv}, 0);
    chk("rst_a_refr", {31'b0, a_refr}, 0);
    chk("rst_v_refr", {31'b0, v_refr}, 0);
    rst_n = 1;
    quiet(5);
    // held-high atrial level: single sense, ARP window, re-sense only after a low
    clr();
    atrial_raw = 1;
    repeat (20) tick();
    chk("t1_latency", first_sa, 5);
    chk("t1_sa_count", n_sa, 1);
    chk("t1_arp_len", n_ar, ARP);
    quiet(6);
    clr();
    atrial_raw = 1;
    repeat (10) tick();
    chk("t1_resense", n_sa, 1);
    quiet(20);
    // ventricular glitch rejected, clean pulse senses and blanks the atrium
    clr();
    vent_raw = 1;
    repeat (2) tick();
    quiet(8);
    chk("t2_glitch", n_sv, 0);
    clr();
    vent_raw = 1;
    repeat (3) tick();
    quiet(14);
    chk("t2_sv_count", n_sv, 1);
    chk("t2_vrp_len", n_vr, VRP);
    chk("t2_pvarp_len", n_ar, PVARP);
    quiet(5);
    // atrial pace: ARP hides atrial activity, VBLANK on the ventricle
    clr();
    for (int i = 1; i <= 15; i++) begin
      pa = (i == 1);
      atrial_raw = (i >= 2 && i <= 6);
      tick();
    end
    chk("t3_sa_blocked", n_sa, 0);
    chk("t3_arp_len", n_ar, ARP);
    chk("t3_vblank_len", n_vr, VBLANK);
    quiet(5);
    clr();
    for (int i = 1; i <= 30; i++) begin
      pa = (i == 1);
      vent_raw = (i >= 4 && i <= 7);
      tick();
    end
    chk("t3_sv_count", n_sv, 1);
    chk("t3_v_refr_total", n_vr, VBLANK + VRP);
    chk("t3_a_refr_total", n_ar, ARP + PVARP);
    quiet(5);
    // ventricular pace: PVARP suppresses early atrial activity only
    clr();
    for (int i = 1; i <= 30; i++) begin
      pv = (i == 1);
      atrial_raw = (i >= 4 && i <= 6) || (i >= 13 && i <= 18);
      tick();
    end
    chk("t4_sa_cycle", first_sa, 17);
    chk("t4_sa_count", n_sa, 1);
    chk("t4_vrp_len", n_vr, VRP);
    quiet(5);
    // pace in the qualifying cycle wins over the sense
    clr();
    a_at5 = -1;
    for (int i = 1; i <= 30; i++) begin
      pv = (i == 5);
      atrial_raw = (i <= 6);
      tick();
      if (i == 5) a_at5 = int'(a_refr);
    end
    chk("t5_a_refr_next", a_at5, 1);
    chk("t5_sa_count", n_sa, 0);
    quiet(5);
    // asynchronous reset in the middle of a window
    clr();
    for (int i = 1; i <= 7; i++) begin
      atrial_raw = (i <= 3);
      tick();
    end
    chk("t6_pre_sa", n_sa, 1);
    chk("t6_in_refr", {31'b0, a_refr}, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_sa_zero", {31'b0, sa}, 0);
    chk("t6_sv_zero", {31'b0, sv}, 0);
    chk("t6_a_refr_zero", {31'b0, a_refr}, 0);
    chk("t6_v_refr_zero", {31'b0, v_refr}, 0);
    model_reset();
    repeat (2) tick();
    rst_n = 1;
    clr();
    for (int i = 1; i <= 15; i++) begin
      atrial_raw = (i <= 3);
      tick();
    end
    chk("t6_post_latency", first_sa, 5);
    chk("t6_post_count", n_sa, 1);
    quiet(20);
    // random electrode activity with sporadic paces
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) atrial_raw = ~atrial_raw;
      if ($urandom_range(5) == 0) vent_raw = ~vent_raw;
      pa = ($urandom_range(24) == 0);
      pv = ($urandom_range(24) == 0);
      tick();
    end
    quiet(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
